// File: rtl/lbp_gray_arbiter.sv
// Round-robin read arbiter for the shared 128x128 gray-image read port.
// Supports locked bursts (e.g. 3x3 neighbourhood fetch) and in-order tagged returns.
//
// Ports:
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   req, lock    : per-requester read request / burst lock (sampled together)
//   addr         : packed request addresses, requester i at [i*AW +: AW]
//   gnt          : combinational one-hot accept; transfer when req[i] & gnt[i]
//   rvalid       : registered one-cycle return strobe per requester
//   rdata        : registered shared return data, qualified by rvalid
//   mem_ready    : memory can accept a read this cycle
//   mem_req      : registered read strobe to memory
//   mem_addr     : registered read address to memory
//   mem_rdata    : memory read data, valid LAT cycles after mem_req
//   busy         : registered, high while any read is in flight
module lbp_gray_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int LAT       = 1,
  parameter int BURST_MAX = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic [AW-1:0]      mem_addr,
  input  logic [DW-1:0]      mem_rdata,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    ST_FREE,
    ST_OWNED
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] count_q, count_d;

  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;

  // Return tag pipeline: stage 0 lines up with mem_req,
  // stage LAT lines up with valid mem_rdata.
  logic [LAT:0]          tag_v_q, tag_v_d;
  logic [LAT:0][IW-1:0]  tag_id_q, tag_id_d;

  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] rr_gnt;
  logic            rr_found;
  logic            xfer;
  logic [IW-1:0]   xidx;
  logic [AW-1:0]   xaddr;

  function automatic logic [IW-1:0] rot(
    input logic [IW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  function automatic logic [IW-1:0] inc_idx(
    input logic [IW-1:0] i
  );
    if (int'(i) == NREQ - 1) return '0;
    return i + IW'(1);
  endfunction

  // Round-robin pick: first asserted req from ptr upward.
  always_comb begin
    rr_gnt   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!rr_found && req[rot(ptr_q, k)]) begin
        rr_gnt[rot(ptr_q, k)] = 1'b1;
        rr_found              = 1'b1;
      end
    end
  end

  // A locked owner excludes everyone else, even while idle.
  always_comb begin
    gnt = '0;
    if (!reset && mem_ready) begin
      if (state_q == ST_OWNED) begin
        gnt[owner_q] = req[owner_q];
      end else begin
        gnt = rr_gnt;
      end
    end
  end

  always_comb begin
    xfer  = 1'b0;
    xidx  = '0;
    xaddr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && gnt[i]) begin
        xfer  = 1'b1;
        xidx  = IW'(i);
        xaddr = addr[i*AW +: AW];
      end
    end
  end

  // Ownership / pointer. Everything freezes while mem_ready is low.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    count_d = count_q;
    if (mem_ready) begin
      unique case (state_q)
        ST_OWNED: begin
          count_d = count_q + CW'(xfer);
          if (!lock[owner_q] || count_d >= CW'(BURST_MAX)) begin
            state_d = ST_FREE;
            count_d = '0;
            ptr_d   = inc_idx(owner_q);
          end
        end
        ST_FREE: begin
          if (xfer) begin
            if (lock[xidx] && BURST_MAX > 1) begin
              state_d = ST_OWNED;
              owner_d = xidx;
              count_d = CW'(1);
            end else begin
              ptr_d = inc_idx(xidx);
            end
          end
        end
        default: begin
          state_d = ST_FREE;
        end
      endcase
    end
  end

  // Issue and in-order return.
  always_comb begin
    mem_req_d  = xfer;
    mem_addr_d = mem_addr_q;
    if (xfer) mem_addr_d = xaddr;
    if (LAT > 0) begin
      tag_v_d  = {tag_v_q[LAT-1:0], xfer};
      tag_id_d = {tag_id_q[LAT-1:0], xidx};
    end else begin
      tag_v_d  = xfer;
      tag_id_d = xidx;
    end
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tag_v_q[LAT]) begin
      for (int i = 0; i < NREQ; i++) begin
        if (tag_id_q[LAT] == IW'(i)) rvalid_d[i] = 1'b1;
      end
      rdata_d = mem_rdata;
    end
    busy_d = |tag_v_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FREE;
      ptr_q      <= '0;
      owner_q    <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lbp_gray_arbiter.sv
// Self-checking bench for lbp_gray_arbiter.
// Directed scenarios followed by random traffic against a queue-based model.
module tb_lbp_gray_arbiter;

  localparam int N   = 2;
  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int LAT = 1;
  localparam int BM  = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_v;
  logic [N-1:0]    lock_v;
  logic [N*AW-1:0] addr_v;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            rdy;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  lbp_gray_arbiter #(
    .NREQ(N), .AW(AW), .DW(DW), .LAT(LAT), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req_v), .lock(lock_v), .addr(addr_v),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_ready(rdy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Gray memory: fixed read latency LAT.
  logic [DW-1:0] gmem [16384];
  logic [DW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= gmem[mem_addr];
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mem_rdata = mpipe[LAT-1];

  typedef struct {
    int id;
    int a;
    int due;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_ptr, m_owner, m_cnt;
  logic [N-1:0] pend;
  bit   fix_addr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_ptr   = 0;
    m_owner = -1;
    m_cnt   = 0;
    pend    = '0;
    q.delete();
  endtask

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int j;
    g = '0;
    if (!rdy) return g;
    if (m_owner >= 0) begin
      if (req_v[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (req_v[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_edge(input int x);
    if (!rdy) return;
    if (m_owner >= 0) begin
      if (x >= 0) m_cnt++;
      if (!lock_v[m_owner] || m_cnt >= BM) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
      end
    end else if (x >= 0) begin
      if (lock_v[x]) begin
        m_owner = x;
        m_cnt   = 1;
        if (m_cnt >= BM) begin
          m_ptr   = (x + 1) % N;
          m_owner = -1;
          m_cnt   = 0;
        end
      end else begin
        m_ptr = (x + 1) % N;
      end
    end
  endtask

  // Apply inputs; a requester still waiting keeps its address.
  task automatic set_in(input logic [N-1:0] r,
                        input logic [N-1:0] l,
                        input logic rd);
    for (int i = 0; i < N; i++) begin
      if (fix_addr && i == 0) addr_v[i*AW +: AW] = 14'h0081;
      else if (!pend[i]) addr_v[i*AW +: AW] = AW'($urandom);
    end
    req_v  = r;
    lock_v = l;
    rdy    = rd;
  endtask

  // Entered and left at posedge+1.
  task automatic run_cycle();
    logic [N-1:0]  eg;
    logic [N-1:0]  ev;
    int            x;
    int            a;
    #1;
    eg = model_gnt();
    chk("gnt", 32'(gnt), 32'(eg));
    x = -1;
    a = 0;
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        x = i;
        a = int'(addr_v[i*AW +: AW]);
      end
    end
    @(posedge clk);
    cyc++;
    model_edge(x);
    if (x >= 0) q.push_back('{x, a, cyc + LAT + 1});
    for (int i = 0; i < N; i++) pend[i] = req_v[i] && (x != i);
    #1;
    chk("mem_req", 32'(mem_req), 32'(x >= 0));
    if (x >= 0) chk("mem_addr", 32'(mem_addr), 32'(a));
    ev = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev[q[0].id] = 1'b1;
      chk("rdata", 32'(rdata), 32'(gmem[q[0].a]));
      void'(q.pop_front());
    end
    chk("rvalid", 32'(rvalid), 32'(ev));
    chk("busy", 32'(busy), 32'(q.size() > 0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [N-1:0] r, l;
    for (int i = 0; i < 16384; i++) gmem[i] = DW'($urandom);
    gmem[14'h0081] = 8'h5A;
    reset    = 1'b0;
    req_v    = '0;
    lock_v   = '0;
    addr_v   = '0;
    rdy      = 1'b1;
    fix_addr = 1'b0;
    model_clear();
    #1;
    do_reset();

    // Single requester, fixed address, back-to-back.
    fix_addr = 1'b1;
    repeat (3) begin
      set_in(2'b01, 2'b00, 1'b1);
      run_cycle();
    end
    fix_addr = 1'b0;
    repeat (LAT + 3) begin
      set_in(2'b00, 2'b00, 1'b1);
      run_cycle();
    end

    // Round-robin with both requesting.
    repeat (6) begin
      set_in(2'b11, 2'b00, 1'b1);
      run_cycle();
    end

    // Locked burst hitting BURST_MAX, requester 1 waiting.
    repeat (14) begin
      set_in(2'b11, 2'b01, 1'b1);
      run_cycle();
    end
    set_in(2'b10, 2'b00, 1'b1);
    run_cycle();
    set_in(2'b00, 2'b00, 1'b1);
    run_cycle();

    // Lock released after 4 transfers.
    repeat (4) begin
      set_in(2'b11, 2'b01, 1'b1);
      run_cycle();
    end
    repeat (3) begin
      set_in(2'b11, 2'b00, 1'b1);
      run_cycle();
    end

    // Owner idles while holding the lock.
    set_in(2'b01, 2'b01, 1'b1);
    run_cycle();
    repeat (3) begin
      set_in(2'b10, 2'b01, 1'b1);
      run_cycle();
    end
    set_in(2'b10, 2'b00, 1'b1);
    run_cycle();

    // mem_ready gating with reads in flight.
    repeat (2) begin
      set_in(2'b11, 2'b00, 1'b1);
      run_cycle();
    end
    repeat (5) begin
      set_in(2'b11, 2'b00, 1'b0);
      run_cycle();
    end
    set_in(2'b00, 2'b00, 1'b1);
    repeat (LAT + 3) run_cycle();

    // Reset in the middle of a locked burst.
    repeat (2) begin
      set_in(2'b11, 2'b10, 1'b1);
      run_cycle();
    end
    do_reset();
    set_in(2'b11, 2'b00, 1'b1);
    run_cycle();
    repeat (LAT + 3) begin
      set_in(2'b00, 2'b00, 1'b1);
      run_cycle();
    end

    // Random traffic; waiting requesters keep req high.
    repeat (600) begin
      r = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (pend[i]) r[i] = 1'b1;
        l[i] = ($urandom_range(0, 9) < 6);
      end
      set_in(r, l, ($urandom_range(0, 7) != 0));
      run_cycle();
    end
    set_in(2'b00, 2'b00, 1'b1);
    repeat (LAT + 4) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
